cordic_job_queue: RTL and testbench

- Command/result sequencer placed directly in front of the iterative CORDIC core, between the TinyQV peripheral register file and the core.
- Buffers up to DEPTH operand jobs and issues them to the core one at a time using the core's start/done protocol.
- Captures each core result (out1, out2) into a result FIFO with a sequence tag, so software can batch computations instead of polling one at a time.

---
 rtl/cordic_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 58 +++++
 rtl/cordic_job_queue.sv | 229 ++++++++++++++++++++++
 tb/tb_cordic_job_queue.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC job sequencer: mode codes, FSM states and the
// packed job/result records carried through the two FIFOs.
package cordic_pkg;

  localparam int unsigned CJQ_FIXED_WIDTH = 16;
  localparam int unsigned CJQ_SHIFT_W     = $clog2(CJQ_FIXED_WIDTH);
  localparam int unsigned CJQ_TAG_W       = 4;

  localparam logic [1:0] CORDIC_CIRCULAR   = 2'd0;
  localparam logic [1:0] CORDIC_LINEAR     = 2'd1;
  localparam logic [1:0] CORDIC_HYPERBOLIC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DRAIN
  } cjq_state_t;

  typedef struct packed {
    logic [1:0]                 mode;
    logic                       rotating;
    logic [CJQ_SHIFT_W-1:0]     shift;
    logic [CJQ_FIXED_WIDTH-1:0] a;
    logic [CJQ_FIXED_WIDTH-1:0] b;
    logic [CJQ_TAG_W-1:0]       tag;
  } cjq_job_t;

  typedef struct packed {
    logic [CJQ_FIXED_WIDTH-1:0] out1;
    logic [CJQ_FIXED_WIDTH-1:0] out2;
    logic [CJQ_TAG_W-1:0]       tag;
    logic                       err;
  } cjq_res_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush. A push while full is
// accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_rd    = pop && !empty;
  assign w_wr    = push && (!full || w_rd);
  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; flush behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since empty gates every reader.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/cordic_job_queue.sv
// Job/result sequencer in front of the iterative CORDIC core: queues operand
// jobs, issues them one at a time, and collects tagged results.
module cordic_job_queue
  import cordic_pkg::*;
#(
  parameter int unsigned FIXED_WIDTH = CJQ_FIXED_WIDTH,
  parameter int unsigned SHIFT_W     = $clog2(FIXED_WIDTH),
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TAG_W       = CJQ_TAG_W,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [1:0]               job_mode,
  input  logic                     job_rotating,
  input  logic [SHIFT_W-1:0]       job_shift,
  input  logic [FIXED_WIDTH-1:0]   job_a,
  input  logic [FIXED_WIDTH-1:0]   job_b,
  output logic                     core_start,
  output logic [1:0]               core_mode,
  output logic                     core_rotating,
  output logic [SHIFT_W-1:0]       core_shift,
  output logic [FIXED_WIDTH-1:0]   core_a,
  output logic [FIXED_WIDTH-1:0]   core_b,
  input  logic                     core_done,
  input  logic [FIXED_WIDTH-1:0]   core_out1,
  input  logic [FIXED_WIDTH-1:0]   core_out2,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [FIXED_WIDTH-1:0]   res_out1,
  output logic [FIXED_WIDTH-1:0]   res_out2,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   job_count,
  output logic [$clog2(DEPTH):0]   res_count,
  output logic                     busy,
  output logic                     spurious_err,
  output logic                     irq
);

  localparam int unsigned TO_W    = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam int unsigned JOB_W   = $bits(cjq_job_t);
  localparam int unsigned RES_W   = $bits(cjq_res_t);

  cjq_state_t r_state;
  cjq_state_t w_state_nxt;

  cjq_job_t w_job_in;
  cjq_job_t w_job_head;
  cjq_res_t w_res_in;
  cjq_res_t w_res_head;

  logic w_job_push;
  logic w_job_pop;
  logic w_job_full;
  logic w_job_empty;
  logic w_res_push;
  logic w_res_pop;
  logic w_res_full;
  logic w_res_empty;
  logic w_timeout;

  logic [TAG_W-1:0]       r_tag_ctr;
  logic [TAG_W-1:0]       r_cur_tag;
  logic [TO_W-1:0]        r_to_ctr;
  logic                   r_core_start;
  logic                   r_spurious;
  logic [1:0]             r_core_mode;
  logic                   r_core_rotating;
  logic [SHIFT_W-1:0]     r_core_shift;
  logic [FIXED_WIDTH-1:0] r_core_a;
  logic [FIXED_WIDTH-1:0] r_core_b;

  // A job offered on a flush edge is dropped.
  assign w_job_push = job_valid && !w_job_full && !flush;
  assign w_res_pop  = res_ready && !w_res_empty;
  assign w_timeout  = (r_to_ctr == TO_LAST);

  // Pack the incoming job together with its sequence tag.
  always_comb begin
    w_job_in          = '0;
    w_job_in.mode     = job_mode;
    w_job_in.rotating = job_rotating;
    w_job_in.shift    = job_shift;
    w_job_in.a        = job_a;
    w_job_in.b        = job_b;
    w_job_in.tag      = r_tag_ctr;
  end

  sync_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (DEPTH)
  ) u_job_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (w_job_push),
    .wr_data (w_job_in),
    .pop     (w_job_pop),
    .rd_data (w_job_head),
    .full    (w_job_full),
    .empty   (w_job_empty),
    .count   (job_count)
  );

  sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (w_res_push),
    .wr_data (w_res_in),
    .pop     (w_res_pop),
    .rd_data (w_res_head),
    .full    (w_res_full),
    .empty   (w_res_empty),
    .count   (res_count)
  );

  // Next-state logic plus the FIFO pop/push strobes it owns.
  always_comb begin
    w_state_nxt = r_state;
    w_job_pop   = 1'b0;
    w_res_push  = 1'b0;
    w_res_in    = '0;
    case (r_state)
      ST_IDLE: begin
        // A free result slot is required so a finished job can always land.
        if (!flush && !w_job_empty && !w_res_full) begin
          w_job_pop   = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (core_done || w_timeout) begin
          // Completion on a flush edge is simply discarded; the core is free.
          w_state_nxt   = ST_IDLE;
          w_res_push    = !flush;
          w_res_in.out1 = core_done ? core_out1 : '0;
          w_res_in.out2 = core_done ? core_out2 : '0;
          w_res_in.tag  = r_cur_tag;
          w_res_in.err  = !core_done;
        end else if (flush) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (core_done || w_timeout) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand registers load on dispatch and hold through WAIT/DRAIN; the start
  // pulse is registered out of ISSUE so the core sees settled operands, and it
  // is withheld when ISSUE is flushed so DRAIN never overlaps a fresh start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_core_start    <= 1'b0;
      r_core_mode     <= '0;
      r_core_rotating <= 1'b0;
      r_core_shift    <= '0;
      r_core_a        <= '0;
      r_core_b        <= '0;
      r_cur_tag       <= '0;
    end else begin
      r_core_start <= (r_state == ST_ISSUE) && !flush;
      if (w_job_pop) begin
        r_core_mode     <= w_job_head.mode;
        r_core_rotating <= w_job_head.rotating;
        r_core_shift    <= w_job_head.shift;
        r_core_a        <= w_job_head.a;
        r_core_b        <= w_job_head.b;
        r_cur_tag       <= w_job_head.tag;
      end
    end
  end

  // Sequence tag for accepted jobs; survives flush.
  always_ff @(posedge clk) begin
    if (rst)             r_tag_ctr <= '0;
    else if (w_job_push) r_tag_ctr <= r_tag_ctr + TAG_W'(1);
  end

  // Cycles spent waiting on the core, cleared while issuing.
  always_ff @(posedge clk) begin
    if (rst)                                           r_to_ctr <= '0;
    else if (r_state == ST_ISSUE)                      r_to_ctr <= '0;
    else if (r_state == ST_WAIT || r_state == ST_DRAIN) r_to_ctr <= r_to_ctr + TO_W'(1);
  end

  // Sticky flag for a done pulse when no computation is outstanding.
  always_ff @(posedge clk) begin
    if (rst) r_spurious <= 1'b0;
    else if (core_done && (r_state == ST_IDLE || r_state == ST_ISSUE)) r_spurious <= 1'b1;
  end

  assign job_ready     = !w_job_full;
  assign core_start    = r_core_start;
  assign core_mode     = r_core_mode;
  assign core_rotating = r_core_rotating;
  assign core_shift    = r_core_shift;
  assign core_a        = r_core_a;
  assign core_b        = r_core_b;
  assign res_valid     = !w_res_empty;
  assign res_out1      = w_res_empty ? '0 : w_res_head.out1;
  assign res_out2      = w_res_empty ? '0 : w_res_head.out2;
  assign res_tag       = w_res_empty ? '0 : w_res_head.tag;
  assign res_err       = w_res_empty ? 1'b0 : w_res_head.err;
  assign busy          = (r_state != ST_IDLE);
  assign spurious_err  = r_spurious;
  assign irq           = !w_res_empty;

endmodule

// File: tb/tb_cordic_job_queue.sv
// Scoreboard bench for cordic_job_queue with a simple behavioural core model.
module tb_cordic_job_queue;

  localparam int FW = 16;
  localparam int SW = 4;
  localparam int TW = 4;

  logic          clk;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [1:0]    job_mode;
  logic          job_rotating;
  logic [SW-1:0] job_shift;
  logic [FW-1:0] job_a;
  logic [FW-1:0] job_b;
  logic          core_start;
  logic [1:0]    core_mode;
  logic          core_rotating;
  logic [SW-1:0] core_shift;
  logic [FW-1:0] core_a;
  logic [FW-1:0] core_b;
  logic          core_done;
  logic [FW-1:0] core_out1;
  logic [FW-1:0] core_out2;
  logic          res_valid;
  logic          res_ready;
  logic [FW-1:0] res_out1;
  logic [FW-1:0] res_out2;
  logic [TW-1:0] res_tag;
  logic          res_err;
  logic          flush;
  logic [2:0]    job_count;
  logic [2:0]    res_count;
  logic          busy;
  logic          spurious_err;
  logic          irq;

  cordic_job_queue #(
    .FIXED_WIDTH (FW),
    .SHIFT_W     (SW),
    .DEPTH       (4),
    .TAG_W       (TW),
    .TIMEOUT     (64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .job_valid     (job_valid),
    .job_ready     (job_ready),
    .job_mode      (job_mode),
    .job_rotating  (job_rotating),
    .job_shift     (job_shift),
    .job_a         (job_a),
    .job_b         (job_b),
    .core_start    (core_start),
    .core_mode     (core_mode),
    .core_rotating (core_rotating),
    .core_shift    (core_shift),
    .core_a        (core_a),
    .core_b        (core_b),
    .core_done     (core_done),
    .core_out1     (core_out1),
    .core_out2     (core_out2),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_out1      (res_out1),
    .res_out2      (res_out2),
    .res_tag       (res_tag),
    .res_err       (res_err),
    .flush         (flush),
    .job_count     (job_count),
    .res_count     (res_count),
    .busy          (busy),
    .spurious_err  (spurious_err),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [FW-1:0] o1;
    logic [FW-1:0] o2;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [TW-1:0] exp_tag = '0;
  logic          hang    = 1'b0;
  int            lat     = 14;
  int            inj_req = 0;
  logic          ov_en   = 1'b0;
  int            n_start = 0;
  int            n_done  = 0;

  function automatic logic [FW-1:0] f1(input logic [FW-1:0] a, input logic rot);
    return a ^ 16'h076F ^ (rot ? 16'h0000 : 16'h1000);
  endfunction

  function automatic logic [FW-1:0] f2(input logic [FW-1:0] b, input logic [1:0] m);
    return b ^ 16'h0021 ^ {6'd0, m, 8'd0};
  endfunction

  // Behavioural core: done pulse lat cycles after start unless hanging.
  initial begin
    int            cnt;
    int            inj_ack;
    logic [FW-1:0] ma, mb;
    logic [1:0]    mm;
    logic          mr;
    cnt = 0; inj_ack = 0; ma = '0; mb = '0; mm = '0; mr = 1'b0;
    core_done = 1'b0; core_out1 = '0; core_out2 = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (inj_req != inj_ack) begin
        inj_ack   = inj_req;
        core_done = 1'b1;
      end else if (core_start) begin
        if (ov_en) check_eq("start_after_done", n_start, n_done);
        n_start++;
        if (!hang) begin
          cnt = lat; ma = core_a; mb = core_b; mm = core_mode; mr = core_rotating;
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          core_done = 1'b1;
          core_out1 = f1(ma, mr);
          core_out2 = f2(mb, mm);
          n_done++;
        end
      end
    end
  end

  // Result monitor: compare every popped result against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && res_valid && res_ready) begin
        check_eq("res_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("res_out1", res_out1, e.o1);
          check_eq("res_out2", res_out2, e.o2);
          check_eq("res_tag", res_tag, e.tag);
          check_eq("res_err", res_err, e.err);
          check_eq("irq_level", irq, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic send_job(input logic [1:0] m, input logic rot, input logic [SW-1:0] sh,
                          input logic [FW-1:0] a, input logic [FW-1:0] b);
    int   w;
    exp_t e;
    @(negedge clk);
    job_mode = m; job_rotating = rot; job_shift = sh; job_a = a; job_b = b;
    job_valid = 1'b1;
    w = 0;
    while (!job_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    check_eq("job_accept_wait", job_ready, 1);
    if (job_ready) begin
      @(posedge clk);
      e.o1  = hang ? '0 : f1(a, rot);
      e.o2  = hang ? '0 : f2(b, m);
      e.tag = exp_tag;
      e.err = hang;
      exp_q.push_back(e);
      exp_tag = exp_tag + 1'b1;
      #1;
    end
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int w;
    w = 0;
    while ((busy || job_count != 0 || exp_q.size() != 0) && w < limit) begin
      @(negedge clk);
      w++;
    end
    check_eq("wait_idle", w < limit, 1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 res_ready = v;
  endtask

  initial begin
    int            first;
    int            w;
    int            s0;
    logic [TW-1:0] tag_before;
    rst = 1'b1; flush = 1'b0; job_valid = 1'b0; res_ready = 1'b0;
    job_mode = '0; job_rotating = 1'b0; job_shift = '0; job_a = '0; job_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_job_ready", job_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_core_start", core_start, 0);
    check_eq("rst_counts", {job_count, res_count}, 0);
    check_eq("rst_spurious", spurious_err, 0);
    check_eq("rst_res_outs", {res_out1, res_out2, res_tag, res_err}, 0);

    // Single job: start latency, held operands, result values and irq
    send_job(2'd0, 1'b1, 4'd10, 16'h0400, 16'h0000);
    s0 = n_start;
    first = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (core_start && first < 0) first = k;
    end
    check_eq("start_latency", first, 2);
    check_eq("core_ops", {core_mode, core_rotating, core_shift, core_a, core_b}, {2'd0, 1'b1, 4'd10, 16'h0400, 16'h0000});
    w = 0;
    while (!res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("single_res_wait", res_valid, 1);
    check_eq("single_out1", res_out1, 16'h036F);
    check_eq("single_out2", res_out2, 16'h0021);
    check_eq("single_irq", irq, 1);
    check_eq("single_start_once", n_start - s0, 1);
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    check_eq("single_popped", {irq, res_valid, busy}, 0);

    // Back-to-back jobs with results drained as they arrive
    set_ready(1'b1);
    ov_en = 1'b1;
    for (int i = 0; i < 5; i++)
      send_job(2'(i % 3), 1'(i & 1), 4'd12, 16'(16'h0100 * (i + 1)), 16'(16 * i + 1));
    @(negedge clk);
    check_eq("b2b_job_full", {job_count, job_ready}, {3'd4, 1'b0});
    wait_idle(400);
    ov_en = 1'b0;
    check_eq("b2b_start_done_bal", n_start, n_done);

    // Result backpressure
    set_ready(1'b0);
    for (int i = 0; i < 6; i++)
      send_job(2'd1, 1'b0, 4'd8, 16'(16'h2000 + i), 16'(16'h0300 - i));
    w = 0;
    while ((res_count != 4 || busy) && w < 400) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    check_eq("bp_res_count", res_count, 4);
    check_eq("bp_job_count", job_count, 2);
    check_eq("bp_busy", busy, 0);
    check_eq("bp_ready_valid", {job_ready, res_valid}, 2'b11);
    set_ready(1'b1);
    set_ready(1'b0);
    first = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (core_start && first < 0) first = k;
    end
    check_eq("bp_dispatch_after_pop", first, 2);
    set_ready(1'b1);
    wait_idle(600);

    // Timeout: core never answers
    hang = 1'b1;
    send_job(2'd2, 1'b0, 4'd14, 16'h1234, 16'h4321);
    first = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (res_valid) begin
        first = k;
        break;
      end
    end
    check_eq("timeout_latency", first, 66);
    wait_idle(300);
    hang = 1'b0;
    send_job(2'd0, 1'b1, 4'd13, 16'h0777, 16'h0055);
    wait_idle(300);

    // Flush in WAIT with three jobs queued, plus a job offered on the flush edge
    set_ready(1'b0);
    lat = 40;
    tag_before = exp_tag;
    for (int i = 0; i < 4; i++)
      send_job(2'd0, 1'b1, 4'd9, 16'(16'h0A00 + i), 16'h0001);
    @(negedge clk);
    flush = 1'b1;
    job_valid = 1'b1; job_a = 16'hDEAD; job_b = 16'hBEEF;
    @(posedge clk);
    exp_q.delete();
    #1 flush = 1'b0;
    job_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_counts", {job_count, res_count}, 0);
    check_eq("flush_drain_busy", busy, 1);
    w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("drain_exit", busy, 0);
    repeat (3) @(negedge clk);
    check_eq("drain_discard", {res_valid, res_count}, 0);
    check_eq("drain_spurious", spurious_err, 0);
    set_ready(1'b1);
    lat = 14;
    send_job(2'd1, 1'b1, 4'd7, 16'h0321, 16'h0123);
    w = 0;
    while (!res_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("flush_next_tag", res_tag, 4'(tag_before + 4'd4));
    wait_idle(300);

    // Reset mid-WAIT, then a stray done pulse
    lat = 40;
    send_job(2'd2, 1'b1, 4'd11, 16'h0F00, 16'h00F0);
    repeat (5) @(negedge clk);
    check_eq("pre_reset_busy", busy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_tag = '0;
    @(negedge clk);
    check_eq("mid_rst_state", {busy, job_count, res_count, res_valid}, 0);
    check_eq("mid_rst_core", {core_start, core_mode, core_rotating, core_shift, core_a, core_b}, 0);
    check_eq("mid_rst_res", {res_out1, res_out2, res_tag, res_err}, 0);
    check_eq("mid_rst_spurious", spurious_err, 0);
    inj_req = inj_req + 1;
    repeat (3) @(negedge clk);
    check_eq("spurious_set", spurious_err, 1);
    check_eq("spurious_idle", busy, 0);

    // Tag wrap over 17 jobs
    lat = 3;
    for (int i = 0; i < 17; i++)
      send_job(2'(i % 3), 1'(i & 1), 4'(i), 16'(16'h0040 * i), 16'(16'h1000 - i));
    wait_idle(2000);
    check_eq("tag_wrap_next", exp_tag, 4'd1);
    check_eq("spurious_sticky", spurious_err, 1);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
